// File: rtl/dm_sba_tlul.sv
`default_nettype none
// ============================================================================
// Module   : dm_sba_tlul (with the tlul_pkg bus types it uses)
// Brief    : Debug-module System Bus Access engine that turns sbaddress/sbdata
//            CSR events into single-beat TL-UL host transactions.
//            Optional response watchdog: define DM_SBA_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================

package tlul_pkg;
    parameter int unsigned TL_AW  = 64;
    parameter int unsigned TL_DW  = 64;
    parameter int unsigned TL_DBW = TL_DW / 8;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [2:0]        a_size;
        logic [7:0]        a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [2:0]        d_size;
        logic [7:0]        d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module dm_sba_tlul #(
    parameter int unsigned BusWidth      = 32,
    parameter logic [7:0]  SourceId      = 8'd0,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dmactive_i,
    input  logic [BusWidth-1:0]  sbaddress_i,
    output logic [BusWidth-1:0]  sbaddress_o,
    input  logic                 sbaddress_write_valid_i,
    input  logic                 sbreadonaddr_i,
    input  logic                 sbautoincrement_i,
    input  logic [2:0]           sbaccess_i,
    input  logic                 sbreadondata_i,
    input  logic [BusWidth-1:0]  sbdata_i,
    input  logic                 sbdata_read_valid_i,
    input  logic                 sbdata_write_valid_i,
    output logic [BusWidth-1:0]  sbdata_o,
    output logic                 sbdata_valid_o,
    output logic                 sbbusy_o,
    output logic                 sberror_valid_o,
    output logic [2:0]           sberror_o,
    output tlul_pkg::tl_h2d_t    tl_h_o,
    input  tlul_pkg::tl_d2h_t    tl_h_i
);

    localparam int unsigned c_bytes   = BusWidth / 8;
    localparam int unsigned c_offw    = $clog2(c_bytes);
    localparam logic [2:0]  c_maxsize = 3'(c_offw);

`ifdef DM_SBA_TIMEOUT_EN
    localparam int unsigned         c_wdogw     = $clog2(TimeoutCycles + 1);
    // Counter is 0 on the first WAIT cycle, so firing at limit-2 lands the pulse TimeoutCycles after the handshake.
    localparam logic [c_wdogw-1:0]  c_wdog_last = c_wdogw'(TimeoutCycles - 2);
    logic [c_wdogw-1:0]             r_wdog;
`else
    localparam int unsigned         c_unused_timeout = TimeoutCycles;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

    state_e              r_state;
    logic [BusWidth-1:0] r_sbaddress, r_sbdata, r_a_addr, r_a_data;
    logic                r_sbdata_valid, r_sberror_valid, r_a_valid;
    logic [2:0]          r_sberror, r_a_opcode, r_a_size;
    logic [c_bytes-1:0]  r_a_mask;

    logic                w_idle, w_ev_addr, w_ev_wr, w_ev_rd, w_launch, w_is_write;
    logic                w_size_err, w_align_err, w_unused_rsp;
    logic [BusWidth-1:0] w_addr, w_wdata, w_d_data, w_rshift, w_rdata;
    logic [15:0]         w_lanes;
    logic [c_bytes-1:0]  w_mask;

    // Events are only honoured when idle; address write outranks data write, which outranks data read.
    assign w_idle      = (r_state == S_IDLE) && dmactive_i;
    assign w_ev_addr   = w_idle && sbaddress_write_valid_i;
    assign w_ev_wr     = w_idle && sbdata_write_valid_i;
    assign w_ev_rd     = w_idle && sbdata_read_valid_i && sbreadondata_i;
    assign w_launch    = w_ev_addr ? sbreadonaddr_i : (w_ev_wr || w_ev_rd);
    assign w_is_write  = !w_ev_addr && w_ev_wr;
    assign w_addr      = w_ev_addr ? sbaddress_i : r_sbaddress;
    assign w_size_err  = sbaccess_i > c_maxsize;
    assign w_align_err = (w_addr & ((BusWidth'(1) << sbaccess_i) - BusWidth'(1))) != '0;
    assign w_lanes     = (16'd1 << (5'd1 << sbaccess_i[1:0])) - 16'd1;
    assign w_mask      = c_bytes'(w_lanes << w_addr[c_offw-1:0]);

    always_comb begin
        w_wdata = sbdata_i;
        case (sbaccess_i[1:0])
            2'd0:    w_wdata = {c_bytes{sbdata_i[7:0]}};
            2'd1:    w_wdata = {(c_bytes / 2){sbdata_i[15:0]}};
            2'd2:    w_wdata = {(c_bytes / 4){sbdata_i[31:0]}};
            default: w_wdata = sbdata_i;
        endcase
    end

    assign w_d_data = tl_h_i.d_data[BusWidth-1:0];
    assign w_rshift = w_d_data >> {r_a_addr[c_offw-1:0], 3'b000};

    always_comb begin
        w_rdata = w_rshift;
        case (r_a_size[1:0])
            2'd0:    w_rdata = BusWidth'(w_rshift[7:0]);
            2'd1:    w_rdata = BusWidth'(w_rshift[15:0]);
            2'd2:    w_rdata = BusWidth'(w_rshift[31:0]);
            default: w_rdata = w_rshift;
        endcase
    end

    assign w_unused_rsp = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size,
                            tl_h_i.d_source, tl_h_i.d_sink, tl_h_i.d_data};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= S_IDLE;
            r_sbaddress     <= '0;
            r_sbdata        <= '0;
            r_sbdata_valid  <= 1'b0;
            r_sberror_valid <= 1'b0;
            r_sberror       <= 3'd0;
            r_a_valid       <= 1'b0;
            r_a_opcode      <= tlul_pkg::Get;
            r_a_size        <= 3'd0;
            r_a_addr        <= '0;
            r_a_mask        <= '0;
            r_a_data        <= '0;
`ifdef DM_SBA_TIMEOUT_EN
            r_wdog          <= '0;
`endif
        end else begin
            r_sbdata_valid  <= 1'b0;
            r_sberror_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ev_addr) r_sbaddress <= sbaddress_i;
                    if (w_launch) begin
                        if (w_size_err) begin
                            r_sberror_valid <= 1'b1;
                            r_sberror       <= 3'd4;
                        end else if (w_align_err) begin
                            r_sberror_valid <= 1'b1;
                            r_sberror       <= 3'd3;
                        end else begin
                            r_state    <= S_REQ;
                            r_a_valid  <= 1'b1;
                            r_a_opcode <= !w_is_write ? tlul_pkg::Get :
                                          (sbaccess_i == c_maxsize) ? tlul_pkg::PutFullData :
                                                                      tlul_pkg::PutPartialData;
                            r_a_size   <= sbaccess_i;
                            r_a_addr   <= w_addr;
                            r_a_mask   <= w_mask;
                            r_a_data   <= w_is_write ? w_wdata : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (!dmactive_i) begin
                        r_a_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (tl_h_i.a_ready) begin
                        r_a_valid <= 1'b0;
                        r_state   <= S_WAIT;
`ifdef DM_SBA_TIMEOUT_EN
                        r_wdog    <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (!dmactive_i) begin
                        r_state <= tl_h_i.d_valid ? S_IDLE : S_DRAIN;
                    end else if (tl_h_i.d_valid) begin
                        r_state <= S_IDLE;
                        if (tl_h_i.d_error) begin
                            r_sberror_valid <= 1'b1;
                            r_sberror       <= 3'd2;
                        end else begin
                            if (r_a_opcode == tlul_pkg::Get) begin
                                r_sbdata       <= w_rdata;
                                r_sbdata_valid <= 1'b1;
                            end
                            if (sbautoincrement_i)
                                r_sbaddress <= r_sbaddress + (BusWidth'(1) << r_a_size);
                        end
                    end
`ifdef DM_SBA_TIMEOUT_EN
                    else if (r_wdog == c_wdog_last) begin
                        r_sberror_valid <= 1'b1;
                        r_sberror       <= 3'd1;
                        r_state         <= S_DRAIN;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (tl_h_i.d_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tl_h_o                          = '0;
        tl_h_o.a_valid                  = r_a_valid;
        tl_h_o.a_opcode                 = r_a_opcode;
        tl_h_o.a_size                   = r_a_size;
        tl_h_o.a_source                 = SourceId;
        tl_h_o.a_address[BusWidth-1:0]  = r_a_addr;
        tl_h_o.a_mask[c_bytes-1:0]      = r_a_mask;
        tl_h_o.a_data[BusWidth-1:0]     = r_a_data;
        tl_h_o.d_ready                  = 1'b1;
    end

    assign sbaddress_o     = r_sbaddress;
    assign sbdata_o        = r_sbdata;
    assign sbdata_valid_o  = r_sbdata_valid;
    assign sberror_valid_o = r_sberror_valid;
    assign sberror_o       = r_sberror;
    assign sbbusy_o        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_tlul.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_sba_tlul
// Brief    : Randomised self-checking bench for dm_sba_tlul (32-bit bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_sba_tlul;

    localparam int unsigned BW  = 32;
    localparam int unsigned TO  = 16;
    localparam logic [7:0]  SRC = 8'hA5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              dmactive_i;
    logic [BW-1:0]     sbaddress_i, sbaddress_o, sbdata_i, sbdata_o;
    logic              sbaddress_write_valid_i, sbreadonaddr_i, sbautoincrement_i;
    logic [2:0]        sbaccess_i, sberror_o;
    logic              sbreadondata_i, sbdata_read_valid_i, sbdata_write_valid_i;
    logic              sbdata_valid_o, sbbusy_o, sberror_valid_o;
    tlul_pkg::tl_h2d_t tl_h_o;
    tlul_pkg::tl_d2h_t tl_h_i;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_addr, m_data;

    always #5 clk_i = ~clk_i;

    dm_sba_tlul #(.BusWidth(BW), .SourceId(SRC), .TimeoutCycles(TO)) u_dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .dmactive_i              (dmactive_i),
        .sbaddress_i             (sbaddress_i),
        .sbaddress_o             (sbaddress_o),
        .sbaddress_write_valid_i (sbaddress_write_valid_i),
        .sbreadonaddr_i          (sbreadonaddr_i),
        .sbautoincrement_i       (sbautoincrement_i),
        .sbaccess_i              (sbaccess_i),
        .sbreadondata_i          (sbreadondata_i),
        .sbdata_i                (sbdata_i),
        .sbdata_read_valid_i     (sbdata_read_valid_i),
        .sbdata_write_valid_i    (sbdata_write_valid_i),
        .sbdata_o                (sbdata_o),
        .sbdata_valid_o          (sbdata_valid_o),
        .sbbusy_o                (sbbusy_o),
        .sberror_valid_o         (sberror_valid_o),
        .sberror_o               (sberror_o),
        .tl_h_o                  (tl_h_o),
        .tl_h_i                  (tl_h_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_addr(input logic [31:0] a);
        @(negedge clk_i);
        sbaddress_i = a; sbreadonaddr_i = 1'b0; sbaddress_write_valid_i = 1'b1;
        @(negedge clk_i);
        sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b1;
        m_addr = a;
        check("addr_load", sbaddress_o, m_addr);
        check("addr_load_idle", sbbusy_o, 0);
    endtask

    // kind: 0 = sbaddress write with readonaddr, 1 = sbdata write, 2 = sbdata read
    task automatic run_txn(input int kind, input logic [31:0] addr, input int size,
                           input logic [31:0] wdata, input bit autoinc, input bit derr,
                           input logic [31:0] rdata, input int rdy_dly, input int rsp_dly);
        logic [31:0] use_addr, szmask, elem, exp_wd;
        logic [3:0]  exp_mask;
        int          bytes, off, exp_err, lat, n, err_pulses;
        bit          is_wr, seen_req;
        bytes    = 1 << size;
        is_wr    = (kind == 1);
        use_addr = (kind == 0) ? addr : m_addr;
        if (kind == 0) m_addr = addr;
        exp_err  = (bytes > BW / 8) ? 4 : ((use_addr % bytes) != 0) ? 3 : 0;
        off      = use_addr % 4;
        szmask   = (bytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);

        @(negedge clk_i);
        sbaccess_i = 3'(size); sbautoincrement_i = autoinc; sbdata_i = wdata;
        sbaddress_i = addr; sbreadonaddr_i = 1'b1; sbreadondata_i = 1'b1;
        sbaddress_write_valid_i = (kind == 0);
        sbdata_write_valid_i    = (kind == 1);
        sbdata_read_valid_i     = (kind == 2);
        @(negedge clk_i);
        lat = 1;
        sbaddress_write_valid_i = 1'b0; sbdata_write_valid_i = 1'b0; sbdata_read_valid_i = 1'b0;

        if (exp_err != 0) begin
            err_pulses = 0; seen_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (sberror_valid_o) begin
                    err_pulses++;
                    check("pre_err_code", sberror_o, exp_err);
                end
                if (tl_h_o.a_valid) seen_req = 1'b1;
                @(negedge clk_i);
            end
            check("pre_err_pulses", err_pulses, 1);
            check("pre_no_req", seen_req, 0);
            check("pre_addr", sbaddress_o, m_addr);
            check("pre_data", sbdata_o, m_data);
            check("pre_idle", sbbusy_o, 0);
            return;
        end

        n = 0;
        while (!tl_h_o.a_valid && n < 8) begin @(negedge clk_i); n++; lat++; end
        check("req_valid", tl_h_o.a_valid, 1);
        exp_mask = '0;
        for (int b = 0; b < bytes; b++) exp_mask[off + b] = 1'b1;
        elem = wdata & szmask;
        exp_wd = '0;
        for (int i = 0; i < 4 / bytes; i++) exp_wd = exp_wd | (elem << (8 * bytes * i));
        check("req_opcode", tl_h_o.a_opcode, is_wr ? ((bytes == 4) ? 0 : 1) : 4);
        check("req_size", tl_h_o.a_size, size);
        check("req_source", tl_h_o.a_source, SRC);
        check("req_addr", tl_h_o.a_address, {32'h0, use_addr});
        check("req_mask", tl_h_o.a_mask, {4'h0, exp_mask});
        check("req_dready", tl_h_o.d_ready, 1);
        if (is_wr) check("req_wdata", tl_h_o.a_data, {32'h0, exp_wd});

        for (int i = 0; i < rdy_dly; i++) begin
            check("req_hold", tl_h_o.a_valid, 1);
            @(negedge clk_i); lat++;
        end
        tl_h_i.a_ready = 1'b1;
        @(negedge clk_i); lat++;
        tl_h_i.a_ready = 1'b0;
        check("wait_busy", sbbusy_o, 1);
        check("wait_no_req", tl_h_o.a_valid, 0);
        for (int i = 0; i < rsp_dly; i++) begin @(negedge clk_i); lat++; end

        tl_h_i.d_valid  = 1'b1;
        tl_h_i.d_data   = {$urandom, rdata};
        tl_h_i.d_error  = derr;
        tl_h_i.d_opcode = is_wr ? 3'd0 : 3'd1;
        tl_h_i.d_source = SRC;
        @(negedge clk_i); lat++;
        tl_h_i.d_valid = 1'b0; tl_h_i.d_error = 1'b0;

        if (!derr && !is_wr) m_data = (rdata >> (8 * off)) & szmask;
        if (!derr && autoinc) m_addr = use_addr + 32'(bytes);
        check("rsp_data_pulse", sbdata_valid_o, (!derr && !is_wr));
        check("rsp_err_pulse", sberror_valid_o, derr);
        if (derr) check("rsp_err_code", sberror_o, 2);
        check("rsp_sbdata", sbdata_o, m_data);
        check("rsp_sbaddr", sbaddress_o, m_addr);
        check("rsp_idle", sbbusy_o, 0);
        if (rdy_dly == 0 && rsp_dly == 0) check("latency", lat, 3);
        @(negedge clk_i);
        check("pulse_width", {sbdata_valid_o, sberror_valid_o}, 0);
    endtask

    // Reads at the current (aligned) address and completes the a-channel handshake.
    task automatic launch_and_accept();
        int n;
        @(negedge clk_i);
        sbaccess_i = 3'd2; sbreadondata_i = 1'b1; sbdata_read_valid_i = 1'b1;
        @(negedge clk_i);
        sbdata_read_valid_i = 1'b0;
        n = 0;
        while (!tl_h_o.a_valid && n < 8) begin @(negedge clk_i); n++; end
        check("hs_req", tl_h_o.a_valid, 1);
        tl_h_i.a_ready = 1'b1;
        @(negedge clk_i);
        tl_h_i.a_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int pulses, k, n, kind, size, bytes;
        logic [31:0] a;
        rst_ni = 1'b0; dmactive_i = 1'b1;
        sbaddress_i = '0; sbaddress_write_valid_i = 1'b0; sbreadonaddr_i = 1'b0;
        sbautoincrement_i = 1'b0; sbaccess_i = 3'd2; sbreadondata_i = 1'b0;
        sbdata_i = '0; sbdata_read_valid_i = 1'b0; sbdata_write_valid_i = 1'b0;
        tl_h_i = '0;
        m_addr = '0; m_data = '0;
        repeat (3) @(negedge clk_i);
        check("rst_sbaddr", sbaddress_o, 0);
        check("rst_sbdata", sbdata_o, 0);
        check("rst_busy", sbbusy_o, 0);
        check("rst_pulses", {sbdata_valid_o, sberror_valid_o}, 0);
        check("rst_sberror", sberror_o, 0);
        check("rst_avalid", tl_h_o.a_valid, 0);
        check("rst_dready", tl_h_o.d_ready, 1);
        rst_ni = 1'b1;

        run_txn(0, 32'h1000_0004, 2, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, 0);
        load_addr(32'h2000_0003);
        run_txn(1, 32'h0, 0, 32'h0000_005A, 1'b1, 1'b0, $urandom, 1, 2);
        load_addr(32'h2000_0002);
        run_txn(2, 32'h0, 2, 32'h0, 1'b0, 1'b0, $urandom, 0, 0);
        run_txn(2, 32'h0, 3, 32'h0, 1'b0, 1'b0, $urandom, 0, 0);
        load_addr(32'h3000_0000);
        run_txn(2, 32'h0, 2, 32'h0, 1'b1, 1'b1, $urandom, 0, 1);
        run_txn(0, 32'hFFFF_FFFC, 2, 32'h0, 1'b1, 1'b0, $urandom, 0, 0);
        run_txn(0, 32'h0000_0006, 1, 32'h0, 1'b0, 1'b0, 32'h1234_5678, 0, 0);

        for (int t = 0; t < 60; t++) begin
            kind  = $urandom_range(0, 2);
            size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            bytes = 1 << size;
            a     = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~(32'(bytes) - 32'd1);
            if (kind != 0 && $urandom_range(0, 1) == 1) load_addr(a);
            run_txn(kind, a, size, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // dmactive dropped while the request is still pending on the a-channel
        load_addr(32'h4000_0000);
        sbautoincrement_i = 1'b0;
        @(negedge clk_i);
        sbaccess_i = 3'd2; sbdata_read_valid_i = 1'b1;
        @(negedge clk_i);
        sbdata_read_valid_i = 1'b0;
        n = 0;
        while (!tl_h_o.a_valid && n < 8) begin @(negedge clk_i); n++; end
        check("abort_req_seen", tl_h_o.a_valid, 1);
        dmactive_i = 1'b0;
        @(negedge clk_i);
        check("abort_req_drop", tl_h_o.a_valid, 0);
        check("abort_req_idle", sbbusy_o, 0);
        check("abort_req_pulses", {sbdata_valid_o, sberror_valid_o}, 0);
        dmactive_i = 1'b1;

        // dmactive dropped while waiting for the response
        launch_and_accept();
        dmactive_i = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (sbdata_valid_o || sberror_valid_o) pulses++;
            check("drain_busy", sbbusy_o, 1);
        end
        tl_h_i.d_valid = 1'b1; tl_h_i.d_data = {$urandom, $urandom};
        @(negedge clk_i);
        tl_h_i.d_valid = 1'b0;
        if (sbdata_valid_o || sberror_valid_o) pulses++;
        check("drain_idle", sbbusy_o, 0);
        check("drain_no_pulse", pulses, 0);
        check("drain_data", sbdata_o, m_data);
        dmactive_i = 1'b1;
        run_txn(2, 32'h0, 2, 32'h0, 1'b0, 1'b0, $urandom, 0, 0);

        // Late response: watchdog fires (when built in) or the engine keeps waiting
        launch_and_accept();
        k = 1; pulses = 0;
`ifdef DM_SBA_TIMEOUT_EN
        while (!sberror_valid_o && k < 64) begin @(negedge clk_i); k++; end
        check("wdog_cycles", k, TO);
        check("wdog_code", sberror_o, 1);
        check("wdog_no_data", sbdata_valid_o, 0);
        while (k < 40) begin
            @(negedge clk_i); k++;
            if (sbdata_valid_o || sberror_valid_o) pulses++;
        end
        check("wdog_drain_busy", sbbusy_o, 1);
`else
        while (k < 40) begin
            @(negedge clk_i); k++;
            if (sbdata_valid_o || sberror_valid_o) pulses++;
        end
        check("nowdog_busy", sbbusy_o, 1);
`endif
        check("late_no_pulse", pulses, 0);
        tl_h_i.d_valid = 1'b1; tl_h_i.d_data = {$urandom, 32'hCAFE_F00D};
        @(negedge clk_i);
        tl_h_i.d_valid = 1'b0;
        check("late_idle", sbbusy_o, 0);
`ifdef DM_SBA_TIMEOUT_EN
        check("late_absorbed", {sbdata_valid_o, sberror_valid_o}, 0);
        check("late_data", sbdata_o, m_data);
`else
        m_data = 32'hCAFE_F00D;
        check("late_data_pulse", sbdata_valid_o, 1);
        check("late_data", sbdata_o, m_data);
`endif
        run_txn(1, 32'h0, 2, $urandom, 1'b1, 1'b0, $urandom, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_sba_tlul.md
Name: dm_sba_tlul

Overview:
- Next-generation System Bus Access engine for the debug module.
- Converts sbaddress/sbdata CSR events into single-beat TL-UL host transactions.
- Generalised over bus width (32/64), with native sub-word access (byte masks, lane steering), error capture and a response-timeout watchdog.
- Sits between dm_csrs and the TL-UL host port of the debug module, replacing the dm_sba + generic host-adapter pair.

Parameters:
- BusWidth, 32, TL-UL data width in bits; legal values 32 or 64.
- SourceId, 0, 8-bit a_source value driven on every request.
- TimeoutCycles, 1024, watchdog limit in cycles from request acceptance to response; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- dmactive_i  in  1  debug module active; low aborts and idles the engine
- sbaddress_i  in  BusWidth  address written by the debugger
- sbaddress_o  out  BusWidth  current (auto-incremented) address
- sbaddress_write_valid_i  in  1  pulse: sbaddress written
- sbreadonaddr_i  in  1  start a read on an sbaddress write
- sbautoincrement_i  in  1  increment the address after each successful access
- sbaccess_i  in  3  access size, log2 bytes
- sbreadondata_i  in  1  start a read on an sbdata read
- sbdata_i  in  BusWidth  write data
- sbdata_read_valid_i  in  1  pulse: sbdata read by the debugger
- sbdata_write_valid_i  in  1  pulse: sbdata written (starts a write)
- sbdata_o  out  BusWidth  read data, right-aligned, zero-extended
- sbdata_valid_o  out  1  one-cycle pulse: sbdata_o updated
- sbbusy_o  out  1  engine not idle
- sberror_valid_o  out  1  one-cycle pulse: sberror_o valid
- sberror_o  out  3  error code
- tl_h_o  out  tlul_pkg::tl_h2d_t  TL-UL host request channel
- tl_h_i  in  tlul_pkg::tl_d2h_t  TL-UL host response channel

Behaviour:
- Reset values:
  - sbaddress_o = 0, sbdata_o = 0.
  - All pulses low, sbbusy_o = 0, sberror_o = 0.
  - tl_h_o.a_valid = 0, tl_h_o.d_ready = 1.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE:
  - sbaddress_write_valid_i loads the address next cycle. If sbreadonaddr_i is also set → REQ (read).
  - sbdata_write_valid_i → REQ (write, PutFullData when size equals BusWidth, else PutPartialData).
  - sbdata_read_valid_i with sbreadondata_i → REQ (read, Get).
  - Priority when events coincide: address write, then data write, then data read.
  - Events arriving while sbbusy_o=1 are ignored; dm_csrs flags busyerror.
- Pre-checks on the REQ launch cycle. No bus request is issued; return to IDLE with a one-cycle sberror pulse:
  - sbaccess_i > log2(BusWidth/8) → sberror_o = 4.
  - Address not aligned to 1<<sbaccess_i → sberror_o = 3.
- REQ:
  - a_valid=1, a_size=sbaccess_i, a_source=SourceId.
  - a_mask = ((1<<(1<<size))-1) << addr[log2(BusWidth/8)-1:0].
  - Write data is replicated across all lanes.
  - a_valid is held stable until a_ready. On the handshake → WAIT and the watchdog clears.
- WAIT, when d_valid arrives:
  - d_error=1 → sberror_o = 2. Data and address are unchanged.
  - Otherwise, for a read: sbdata_o = (d_data >> 8*byte_offset) masked to the access size; sbdata_valid_o pulses.
  - Otherwise, if sbautoincrement_i: sbaddress_o += 1<<sbaccess_i, modulo 2^BusWidth.
  - Then → IDLE.
- sbbusy_o is high in REQ, WAIT and DRAIN, and falls in the same cycle the engine returns to IDLE.
- Latency: earliest completion is 3 cycles after the triggering pulse when a_ready and d_valid each respond in one cycle.
- dmactive_i low:
  - In REQ: a_valid drops, → IDLE.
  - In WAIT: → DRAIN, which waits for d_valid and discards the response, then → IDLE.
  - No pulses are generated in either case.
- d_ready is held at 1 in every state.
- Exactly one outstanding transaction at any time.

Optional Feature:
- Macro: DM_SBA_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TimeoutCycles+1) runs in WAIT.
  - On reaching TimeoutCycles: sberror_o = 1 pulses, → DRAIN.
  - The late response is discarded in DRAIN.
- Undefined:
  - No counter is implemented; WAIT lasts indefinitely.
  - Code 1 is never produced.

Test Plan:
- BusWidth=32, write 0x1000_0004 with readonaddr=1, sbaccess=2; device returns 0xDEAD_BEEF → Get, a_mask=0xF; sbdata_o=0xDEADBEEF, single sbdata_valid_o pulse, sbaddress_o stays 0x1000_0004.
- sbaccess=0, address 0x...03, sbdata_i=0x5A → PutPartialData, a_mask=0x8, a_data=0x5A5A5A5A; with autoincrement, sbaddress_o = 0x...04.
- sbaccess=2 at address 0x...02 → no a_valid, sberror_o=3 pulse; sbaccess=3 with BusWidth=32 → sberror_o=4 pulse.
- Device returns d_error=1 on a read → sberror_o=2, sbdata_o unchanged, sbaddress_o not incremented.
- With DM_SBA_TIMEOUT_EN and TimeoutCycles=16, no response → sberror_o=1 exactly 16 cycles after a_ready; a response at cycle 40 is absorbed, sbbusy_o falls then.
- dmactive_i deasserted in WAIT → no pulses; sbbusy_o stays high until d_valid, then falls; a new request afterwards completes normally.
